// File: rtl/xpb_seg_accum_ctrl.sv
// xpb_seg_accum_ctrl
// Shares one registered XPB lookup bank across all NSEG reduction segments.
// A job of NSEG packed digits is issued one (segment, digit) lookup per cycle.
// The returned precomputed multiples are summed into one un-reduced value for
// the downstream reduction adder.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and payload stable
// until that edge. in_ready is 1 only in IDLE. out_valid is 1 only in DONE,
// and out_sum does not change while it waits for out_ready. Because the two
// handshakes are taken in different states, a job can never be accepted on
// the same edge as an out_sum handshake.
module xpb_seg_accum_ctrl #(
  parameter int NSEG    = 8,
  parameter int DIGIT_W = 5,
  parameter int DATA_W  = 1024,
  parameter int SEG_W   = $clog2(NSEG),
  parameter int ACC_W   = DATA_W + SEG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSEG*DIGIT_W-1:0] in_digits,
  output logic                    tbl_en,
  output logic [SEG_W-1:0]        tbl_seg,
  output logic [DIGIT_W-1:0]      tbl_idx,
  input  logic [DATA_W-1:0]       tbl_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NSEG - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [SEG_W-1:0]        r_cnt;
  logic [NSEG*DIGIT_W-1:0] r_digits;
  logic                    r_rd_vld;
  logic [ACC_W-1:0]        r_acc;
  logic                    w_accept;
  logic                    w_last_issue;

  assign w_accept     = (r_state == S_IDLE) && in_valid;
  assign w_last_issue = (r_state == S_ISSUE) && (r_cnt == LAST_SEG);

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> ISSUE (NSEG cycles) -> DRAIN -> DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_next = S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN:                   w_next = S_DONE;
      S_DONE:  if (out_ready)    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    in_ready  = 1'b0;
    tbl_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_ISSUE: tbl_en    = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Segment counter and digit latch. The counter stops at the last segment,
  // so tbl_seg and tbl_idx keep their last values while tbl_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_digits <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_digits <= in_digits;
    end else if ((r_state == S_ISSUE) && !w_last_issue) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Read-valid tracks the one-cycle table latency. The table has no reset,
  // so tbl_data is only ever looked at when r_rd_vld says it is a live result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_rd_vld <= tbl_en;
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_rd_vld) begin
        r_acc <= r_acc + {{SEG_W{1'b0}}, tbl_data};
      end
    end
  end

  assign tbl_seg = r_cnt;
  assign tbl_idx = r_digits[int'(r_cnt)*DIGIT_W +: DIGIT_W];
  assign out_sum = r_acc;

endmodule
